// File: rtl/rx_udp_axi_lite.sv
// UDP receive buffer: packs payload bytes little-endian into a word FIFO and
// exposes header fields, status and payload through an AXI4-Lite register map.
//
// state   | meaning
// IDLE    | waiting for a UDP header
// PAYLOAD | accepting payload bytes into the FIFO
// DONE    | packet complete, waiting for software release
module rx_udp_axi_lite #(
  parameter int DEPTH      = 16,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_udp_hdr_valid,
  output logic        s_udp_hdr_ready,
  input  logic [31:0] s_ip_src,
  input  logic [15:0] s_src_port,
  input  logic [15:0] s_dest_port,
  input  logic [15:0] s_udp_length,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic        s_axis_tready,
  input  logic        w_addr_val,
  input  logic [31:0] wr_addr,
  output logic        wr_adrrdy,
  input  logic        w_dta_val,
  input  logic [31:0] wr_data,
  output logic        wr_dtardy,
  output logic [1:0]  wr_resp,
  output logic        wr_resp_val,
  input  logic        wr_resp_rdy_mas,
  input  logic        radrval,
  input  logic [31:0] raddr,
  output logic        r_addr_rdy,
  output logic [31:0] r_dta,
  output logic [1:0]  rd_resp,
  output logic        r_dta_val,
  input  logic        rd_dta_rsp_rdy
);

  typedef enum logic [1:0] {IDLE, PAYLOAD, DONE} state_t;

  localparam logic [DEPTH_LOG2:0]   LVL_FULL = (DEPTH_LOG2+1)'(DEPTH);
  localparam logic [DEPTH_LOG2:0]   LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  state_t state, state_nx;

  logic [31:0] ip_src_q;
  logic [15:0] src_port_q, dest_port_q, udp_length_q, byte_cnt, cnt_inc;
  logic        err_tuser, err_len;
  logic [31:0] accum, word_in;
  logic [1:0]  lane;

  logic [31:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]   fifo_level;
  logic                  fifo_full, fifo_empty;

  logic hdr_fire, beat, push, pop, flush;
  logic wr_fire, wr_sel_ctrl, rd_fire;
  logic [2:0]  rd_sel;
  logic [31:0] rd_mux, status;
  logic        rd_err;
  logic        unused_bits;

  assign unused_bits = ^{wr_addr[31:5], wr_addr[1:0], raddr[31:5], raddr[1:0], wr_data[31:1]};

  assign fifo_full  = (fifo_level == LVL_FULL);
  assign fifo_empty = (fifo_level == '0);

  assign hdr_fire = s_udp_hdr_valid & (state == IDLE);
  assign beat     = s_axis_tvalid & (state == PAYLOAD) & !fifo_full;
  assign lane     = byte_cnt[1:0];
  assign word_in  = accum | ({24'b0, s_axis_tdata} << {lane, 3'b000});
  assign push     = beat & ((lane == 2'd3) | s_axis_tlast);
  assign cnt_inc  = (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;

  assign wr_fire     = w_addr_val & w_dta_val & !wr_resp_val;
  assign wr_adrrdy   = wr_fire;
  assign wr_dtardy   = wr_fire;
  assign wr_sel_ctrl = (wr_addr[4:2] == 3'd5);
  assign flush       = wr_fire & wr_sel_ctrl & wr_data[0] & (state == DONE);

  assign r_addr_rdy = !r_dta_val;
  assign rd_fire    = radrval & r_addr_rdy;
  assign rd_sel     = raddr[4:2];
  // a release in the same cycle wins over a DATA pop
  assign pop        = rd_fire & (rd_sel == 3'd4) & !fifo_empty & !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx        = state;
    s_udp_hdr_ready = 1'b0;
    s_axis_tready   = 1'b0;
    case (state)
      IDLE: begin
        s_udp_hdr_ready = 1'b1;
        if (hdr_fire) state_nx = PAYLOAD;
      end
      PAYLOAD: begin
        s_axis_tready = !fifo_full;
        if (beat && s_axis_tlast) state_nx = DONE;
      end
      DONE: if (flush) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ip_src_q     <= '0;
      src_port_q   <= '0;
      dest_port_q  <= '0;
      udp_length_q <= '0;
      byte_cnt     <= '0;
      err_tuser    <= 1'b0;
      err_len      <= 1'b0;
      accum        <= '0;
    end else if (hdr_fire) begin
      ip_src_q     <= s_ip_src;
      src_port_q   <= s_src_port;
      dest_port_q  <= s_dest_port;
      udp_length_q <= s_udp_length;
      byte_cnt     <= '0;
      err_tuser    <= 1'b0;
      err_len      <= 1'b0;
      accum        <= '0;
    end else if (beat) begin
      byte_cnt <= cnt_inc;
      accum    <= push ? 32'd0 : word_in;
      if (s_axis_tlast) begin
        err_tuser <= s_axis_tuser;
        err_len   <= (cnt_inc != udp_length_q - 16'd8) | (udp_length_q < 16'd8);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= word_in;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      fifo_level <= fifo_level + LVL_ONE;
      else if (pop && !push) fifo_level <= fifo_level - LVL_ONE;
    end
  end

  assign status = {{(32-DEPTH_LOG2-9){1'b0}}, fifo_level, 3'b000,
                   fifo_full, fifo_empty, err_len, err_tuser, (state == DONE)};

  always_comb begin
    rd_mux = 32'd0;
    rd_err = 1'b0;
    case (rd_sel)
      3'd0: rd_mux = status;
      3'd1: rd_mux = ip_src_q;
      3'd2: rd_mux = {src_port_q, dest_port_q};
      3'd3: rd_mux = {byte_cnt, udp_length_q};
      3'd4: begin
        if (fifo_empty) rd_err = 1'b1;
        else            rd_mux = mem[rd_ptr];
      end
      default: rd_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_dta     <= '0;
      rd_resp   <= '0;
      r_dta_val <= 1'b0;
    end else if (rd_fire) begin
      r_dta     <= rd_mux;
      rd_resp   <= rd_err ? RESP_SLVERR : RESP_OKAY;
      r_dta_val <= 1'b1;
    end else if (r_dta_val && rd_dta_rsp_rdy) begin
      r_dta_val <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_resp     <= '0;
      wr_resp_val <= 1'b0;
    end else if (wr_fire) begin
      wr_resp     <= wr_sel_ctrl ? RESP_OKAY : RESP_SLVERR;
      wr_resp_val <= 1'b1;
    end else if (wr_resp_val && wr_resp_rdy_mas) begin
      wr_resp_val <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rx_udp_axi_lite.sv
// Directed bench for rx_udp_axi_lite: header/payload packing, register reads,
// backpressure at FIFO full, AXI error responses and mid-packet reset.
module tb_rx_udp_axi_lite;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_udp_hdr_valid, s_udp_hdr_ready;
  logic [31:0] s_ip_src;
  logic [15:0] s_src_port, s_dest_port, s_udp_length;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tuser, s_axis_tready;
  logic        w_addr_val, wr_adrrdy, w_dta_val, wr_dtardy;
  logic [31:0] wr_addr, wr_data;
  logic [1:0]  wr_resp;
  logic        wr_resp_val, wr_resp_rdy_mas;
  logic        radrval, r_addr_rdy, r_dta_val, rd_dta_rsp_rdy;
  logic [31:0] raddr, r_dta;
  logic [1:0]  rd_resp;

  int n_checks = 0;
  int n_errors = 0;

  localparam int BUDGET = 40;

  rx_udp_axi_lite #(.DEPTH(16), .DEPTH_LOG2(4)) dut (
    .clk(clk), .rst(rst),
    .s_udp_hdr_valid(s_udp_hdr_valid), .s_udp_hdr_ready(s_udp_hdr_ready),
    .s_ip_src(s_ip_src), .s_src_port(s_src_port), .s_dest_port(s_dest_port),
    .s_udp_length(s_udp_length),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast),
    .s_axis_tuser(s_axis_tuser), .s_axis_tready(s_axis_tready),
    .w_addr_val(w_addr_val), .wr_addr(wr_addr), .wr_adrrdy(wr_adrrdy),
    .w_dta_val(w_dta_val), .wr_data(wr_data), .wr_dtardy(wr_dtardy),
    .wr_resp(wr_resp), .wr_resp_val(wr_resp_val), .wr_resp_rdy_mas(wr_resp_rdy_mas),
    .radrval(radrval), .raddr(raddr), .r_addr_rdy(r_addr_rdy),
    .r_dta(r_dta), .rd_resp(rd_resp), .r_dta_val(r_dta_val), .rd_dta_rsp_rdy(rd_dta_rsp_rdy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [31:0] ip, input logic [15:0] sp, input logic [15:0] dp,
                          input logic [15:0] len);
    int n = 0;
    s_ip_src = ip; s_src_port = sp; s_dest_port = dp; s_udp_length = len;
    s_udp_hdr_valid = 1'b1;
    while (!s_udp_hdr_ready && n < BUDGET) begin step(); n++; end
    chk("hdr_ready", 32'(s_udp_hdr_ready), 32'd1);
    step();
    s_udp_hdr_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic last, input logic user);
    int n = 0;
    s_axis_tdata = d; s_axis_tlast = last; s_axis_tuser = user;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < BUDGET) begin step(); n++; end
    chk("byte_accept", 32'(s_axis_tready), 32'd1);
    step();
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; s_axis_tuser = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    raddr = addr;
    radrval = 1'b1;
    while (!r_addr_rdy && n < BUDGET) begin step(); n++; end
    step();
    radrval = 1'b0;
    chk("rd_valid", 32'(r_dta_val), 32'd1);
    d = r_dta;
    r = rd_resp;
    rd_dta_rsp_rdy = 1'b1;
    step();
    rd_dta_rsp_rdy = 1'b0;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] r);
    int n = 0;
    wr_addr = addr; wr_data = data;
    w_addr_val = 1'b1; w_dta_val = 1'b1;
    while (!wr_adrrdy && n < BUDGET) begin step(); n++; end
    step();
    w_addr_val = 1'b0; w_dta_val = 1'b0;
    chk("wr_valid", 32'(wr_resp_val), 32'd1);
    r = wr_resp;
    wr_resp_rdy_mas = 1'b1;
    step();
    wr_resp_rdy_mas = 1'b0;
  endtask

  logic [31:0] rd;
  logic [1:0]  rr, wr;

  initial begin
    rst = 1'b0;
    s_udp_hdr_valid = 0; s_ip_src = 0; s_src_port = 0; s_dest_port = 0; s_udp_length = 0;
    s_axis_tdata = 0; s_axis_tvalid = 0; s_axis_tlast = 0; s_axis_tuser = 0;
    w_addr_val = 0; wr_addr = 0; w_dta_val = 0; wr_data = 0; wr_resp_rdy_mas = 0;
    radrval = 0; raddr = 0; rd_dta_rsp_rdy = 0;
    repeat (3) step();
    chk("rst_tready", 32'(s_axis_tready), 32'd0);
    chk("rst_rvalid", 32'(r_dta_val), 32'd0);
    chk("rst_wvalid", 32'(wr_resp_val), 32'd0);
    rst = 1'b1;
    step();
    chk("idle_hdr_ready", 32'(s_udp_hdr_ready), 32'd1);
    chk("idle_raddr_rdy", 32'(r_addr_rdy), 32'd1);
    axi_read(32'h00, rd, rr);
    chk("rst_status", rd, 32'h0000_0008);

    // T1: five-byte packet, correct length
    send_hdr(32'hC0A8_0105, 16'h1234, 16'h5678, 16'd13);
    send_byte(8'h11, 0, 0);
    send_byte(8'h22, 0, 0);
    send_byte(8'h33, 0, 0);
    send_byte(8'h44, 0, 0);
    send_byte(8'h55, 1, 0);
    chk("done_tready", 32'(s_axis_tready), 32'd0);
    axi_read(32'h00, rd, rr);
    chk("t1_status", rd, 32'h0000_0201);
    axi_read(32'h04, rd, rr);
    chk("t1_srcip", rd, 32'hC0A8_0105);
    axi_read(32'h08, rd, rr);
    chk("t1_ports", rd, 32'h1234_5678);
    axi_read(32'h0C, rd, rr);
    chk("t1_len", rd, 32'h0005_000D);
    axi_read(32'h10, rd, rr);
    chk("t1_data0", rd, 32'h4433_2211);
    chk("t1_data0_resp", 32'(rr), 32'd0);
    axi_read(32'h10, rd, rr);
    chk("t1_data1", rd, 32'h0000_0055);
    axi_read(32'h00, rd, rr);
    chk("t1_status_empty", rd, 32'h0000_0009);
    axi_write(32'h14, 32'h1, wr);
    chk("t1_release_resp", 32'(wr), 32'd0);
    axi_read(32'h00, rd, rr);
    chk("t1_status_rel", rd, 32'h0000_0008);
    chk("t1_hdr_ready", 32'(s_udp_hdr_ready), 32'd1);

    // T2: length mismatch and tuser error on last beat
    send_hdr(32'h0A00_0001, 16'h0001, 16'h0002, 16'd20);
    send_byte(8'hA0, 0, 0);
    send_byte(8'hA1, 0, 0);
    send_byte(8'hA2, 0, 0);
    send_byte(8'hA3, 0, 0);
    send_byte(8'hA4, 1, 1);
    axi_read(32'h00, rd, rr);
    chk("t2_status", rd, 32'h0000_0207);
    axi_write(32'h14, 32'h1, wr);
    axi_read(32'h00, rd, rr);
    chk("t2_status_rel", rd, 32'h0000_000E);
    axi_read(32'h10, rd, rr);
    chk("t2_flushed_data", rd, 32'h0);
    chk("t2_flushed_resp", 32'(rr), 32'd2);

    // T3: 80-byte packet fills the FIFO at 64 bytes
    send_hdr(32'h0102_0304, 16'hAAAA, 16'hBBBB, 16'd88);
    for (int i = 0; i < 64; i++) send_byte(8'(i), 0, 0);
    chk("t3_full_tready", 32'(s_axis_tready), 32'd0);
    axi_read(32'h00, rd, rr);
    chk("t3_status_full", rd, 32'h0000_1010);
    axi_read(32'h10, rd, rr);
    chk("t3_data0", rd, 32'h0302_0100);
    chk("t3_tready_after_pop", 32'(s_axis_tready), 32'd1);
    for (int i = 64; i < 68; i++) send_byte(8'(i), 0, 0);
    chk("t3_refull_tready", 32'(s_axis_tready), 32'd0);
    axi_read(32'h0C, rd, rr);
    chk("t3_len", rd, 32'h0044_0058);

    // T5: hold the read response for 5 cycles with the address still offered
    raddr = 32'h10;
    radrval = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("t5_rdata_hold", r_dta, 32'h0706_0504);
      chk("t5_raddr_rdy", 32'(r_addr_rdy), 32'd0);
      step();
    end
    radrval = 1'b0;
    rd_dta_rsp_rdy = 1'b1;
    step();
    rd_dta_rsp_rdy = 1'b0;
    axi_read(32'h00, rd, rr);
    chk("t5_single_pop", rd, 32'h0000_0F00);

    // T6: release ignored in PAYLOAD, then reset mid-packet
    axi_write(32'h14, 32'h1, wr);
    chk("t6_release_resp", 32'(wr), 32'd0);
    axi_read(32'h00, rd, rr);
    chk("t6_status_unchanged", rd, 32'h0000_0F00);
    rst = 1'b0;
    #1;
    chk("t6_rst_tready", 32'(s_axis_tready), 32'd0);
    chk("t6_rst_rdata", r_dta, 32'h0);
    chk("t6_rst_rvalid", 32'(r_dta_val), 32'd0);
    chk("t6_rst_wresp", 32'(wr_resp), 32'd0);
    step();
    rst = 1'b1;
    step();
    axi_read(32'h00, rd, rr);
    chk("t6_status", rd, 32'h0000_0008);
    axi_read(32'h0C, rd, rr);
    chk("t6_len", rd, 32'h0);

    // T4: error responses
    axi_read(32'h10, rd, rr);
    chk("t4_empty_data", rd, 32'h0);
    chk("t4_empty_resp", 32'(rr), 32'd2);
    axi_write(32'h04, 32'hDEAD_BEEF, wr);
    chk("t4_bad_wr_resp", 32'(wr), 32'd2);
    axi_read(32'h18, rd, rr);
    chk("t4_bad_rd_resp", 32'(rr), 32'd2);
    axi_read(32'hFFFF_FF08, rd, rr);
    chk("t4_alias_resp", 32'(rr), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
